// File: rtl/counter_pkg.sv
// Shared defaults and direction encodings for the cascaded digit counter.
package counter_pkg;
  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_NUM_DIGITS = 4;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/digit_cell.sv
// One counter digit: value register with per-digit max, clamped load and a
// terminal-count flag that the parent ripples into the next digit's step.
module digit_cell
  import counter_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic [DIGIT_W-1:0] max_val,
  input  logic               step,
  input  logic               dir,
  output logic [DIGIT_W-1:0] value,
  output logic               tc
);

  function automatic logic [DIGIT_W-1:0] clamp(input logic [DIGIT_W-1:0] v,
                                               input logic [DIGIT_W-1:0] m);
    return (v > m) ? m : v;
  endfunction

  // Terminal count is direction-aware: at max going up, at zero going down.
  assign tc = (dir == DIR_UP) ? (value == max_val) : (value == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= clamp(load_val, max_val);
    end else if (step) begin
      if (dir == DIR_UP) begin
        value <= (value == max_val) ? '0 : value + DIGIT_W'(1);
      end else begin
        value <= (value == '0) ? max_val : value - DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_digit_counter.sv
// Cascaded up/down digit counter with per-digit maxima, wrap or saturate
// on chain overflow/underflow, and a registered wrap pulse.
module multi_digit_counter
  import counter_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] MAX_VALS = {NUM_DIGITS{DIGIT_W'(9)}},
  parameter int WRAP_EN    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flag,
  input  logic                          dir,
  input  logic                          clear,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic                          wrap,
  output logic                          at_limit
);

  logic [NUM_DIGITS:0]   chain;
  logic [NUM_DIGITS-1:0] tc;
  logic                  sat_hold;

  // chain[i] is high when every digit below i sits at its terminal count.
  assign chain[0] = 1'b1;
  assign at_limit = chain[NUM_DIGITS];
  assign sat_hold = (WRAP_EN == 0) && at_limit;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign chain[g+1] = chain[g] & tc[g];

    digit_cell #(
      .DIGIT_W(DIGIT_W)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .load    (load),
      .load_val(load_val[g*DIGIT_W +: DIGIT_W]),
      .max_val (MAX_VALS[g*DIGIT_W +: DIGIT_W]),
      .step    (flag & chain[g] & ~sat_hold),
      .dir     (dir),
      .value   (digits[g*DIGIT_W +: DIGIT_W]),
      .tc      (tc[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || clear || load) begin
      wrap <= 1'b0;
    end else begin
      wrap <= flag && at_limit && (WRAP_EN != 0);
    end
  end

endmodule

// File: tb/tb_multi_digit_counter.sv
// Bench for multi_digit_counter: three configurations against a mixed-radix
// integer model, directed scenarios followed by randomized traffic.
module tb_multi_digit_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flag, dir, clear, load;
  logic [15:0] load_val;
  logic [7:0]  load_val2;
  logic [15:0] digits0, digits2;
  logic [7:0]  digits1;
  logic wrap0, wrap1, wrap2, at_limit0, at_limit1, at_limit2;

  int total_cnt = 0;
  int bad_cnt   = 0;

  multi_digit_counter u_dut0 (
    .clk(clk), .rst(rst), .flag(flag), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .digits(digits0), .wrap(wrap0), .at_limit(at_limit0)
  );

  multi_digit_counter #(.NUM_DIGITS(2), .DIGIT_W(4), .MAX_VALS(8'h59)) u_dut1 (
    .clk(clk), .rst(rst), .flag(flag), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val2), .digits(digits1), .wrap(wrap1), .at_limit(at_limit1)
  );

  multi_digit_counter #(.WRAP_EN(0)) u_dut2 (
    .clk(clk), .rst(rst), .flag(flag), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .digits(digits2), .wrap(wrap2), .at_limit(at_limit2)
  );

  // Model: each counter is one integer in a mixed radix given by its maxima.
  int          nd[3]  = '{4, 2, 4};
  logic [31:0] mx[3]  = '{32'h9999, 32'h59, 32'h9999};
  int          wen[3] = '{1, 1, 0};
  int          mval[3];
  logic        mwrap[3];

  function automatic int radix(int k, int i);
    return int'(mx[k][i*4 +: 4]) + 1;
  endfunction

  function automatic int tot(int k);
    int p = 1;
    for (int i = 0; i < nd[k]; i++) p = p * radix(k, i);
    return p;
  endfunction

  function automatic int vec2int(int k, logic [31:0] v);
    int acc = 0;
    int f;
    for (int i = nd[k] - 1; i >= 0; i--) begin
      f = int'(v[i*4 +: 4]);
      if (f > radix(k, i) - 1) f = radix(k, i) - 1;
      acc = acc * radix(k, i) + f;
    end
    return acc;
  endfunction

  function automatic logic [31:0] int2vec(int k, int val);
    logic [31:0] v = '0;
    for (int i = 0; i < nd[k]; i++) begin
      v[i*4 +: 4] = 4'(val % radix(k, i));
      val = val / radix(k, i);
    end
    return v;
  endfunction

  function automatic logic [31:0] dut_digits(int k);
    case (k)
      0:       return {16'h0, digits0};
      1:       return {24'h0, digits1};
      default: return {16'h0, digits2};
    endcase
  endfunction

  function automatic logic dut_wrap(int k);
    case (k)
      0:       return wrap0;
      1:       return wrap1;
      default: return wrap2;
    endcase
  endfunction

  function automatic logic dut_lim(int k);
    case (k)
      0:       return at_limit0;
      1:       return at_limit1;
      default: return at_limit2;
    endcase
  endfunction

  task automatic tick();
    logic [31:0] lv;
    for (int k = 0; k < 3; k++) begin
      lv = (k == 1) ? {24'h0, load_val2} : {16'h0, load_val};
      mwrap[k] = 1'b0;
      if (rst || clear) begin
        mval[k] = 0;
      end else if (load) begin
        mval[k] = vec2int(k, lv);
      end else if (flag) begin
        if (dir) begin
          if (mval[k] == tot(k) - 1) begin
            if (wen[k] != 0) begin mval[k] = 0; mwrap[k] = 1'b1; end
          end else mval[k] = mval[k] + 1;
        end else begin
          if (mval[k] == 0) begin
            if (wen[k] != 0) begin mval[k] = tot(k) - 1; mwrap[k] = 1'b1; end
          end else mval[k] = mval[k] - 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flag = 0; clear = 0; load = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    dir = 1; do_reset();
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (dut_digits(k) !== 32'h0) begin
        bad_cnt++; $display("FAIL reset_digits dut%0d got=%h want=0", k, dut_digits(k));
      end
      total_cnt++;
      if (dut_wrap(k) !== 1'b0) begin
        bad_cnt++; $display("FAIL reset_wrap dut%0d got=%b want=0", k, dut_wrap(k));
      end
      total_cnt++;
      if (dut_lim(k) !== 1'b0) begin
        bad_cnt++; $display("FAIL reset_limit_up dut%0d got=%b want=0", k, dut_lim(k));
      end
    end
    dir = 0; #1;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (dut_lim(k) !== 1'b1) begin
        bad_cnt++; $display("FAIL reset_limit_down dut%0d got=%b want=1", k, dut_lim(k));
      end
    end
  endtask

  task automatic test_long_count();
    int wraps = 0;
    do_reset();
    dir = 1; flag = 1;
    for (int n = 0; n < 9999; n++) begin
      tick();
      if (wrap0) wraps++;
    end
    total_cnt++;
    if (digits0 !== 16'h9999) begin
      bad_cnt++; $display("FAIL long_9999 got=%h want=9999", digits0);
    end
    total_cnt++;
    if (wraps != 0) begin
      bad_cnt++; $display("FAIL long_early_wrap got=%0d want=0", wraps);
    end
    tick();
    total_cnt++;
    if (digits0 !== 16'h0000 || wrap0 !== 1'b1) begin
      bad_cnt++; $display("FAIL long_rollover got=%h/%b want=0000/1", digits0, wrap0);
    end
    flag = 0; tick();
    total_cnt++;
    if (wrap0 !== 1'b0) begin
      bad_cnt++; $display("FAIL long_wrap_one_cycle got=%b want=0", wrap0);
    end
  endtask

  task automatic test_two_digit();
    idle(); load = 1; load_val2 = 8'h58; load_val = 16'h0; tick();
    load = 0; dir = 1; flag = 1; tick();
    total_cnt++;
    if (digits1 !== 8'h59 || wrap1 !== 1'b0) begin
      bad_cnt++; $display("FAIL two_digit_59 got=%h/%b want=59/0", digits1, wrap1);
    end
    tick();
    total_cnt++;
    if (digits1 !== 8'h00 || wrap1 !== 1'b1) begin
      bad_cnt++; $display("FAIL two_digit_wrap got=%h/%b want=00/1", digits1, wrap1);
    end
    flag = 0; tick();
    total_cnt++;
    if (digits1 !== 8'h00 || wrap1 !== 1'b0) begin
      bad_cnt++; $display("FAIL two_digit_idle got=%h/%b want=00/0", digits1, wrap1);
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    dir = 0; flag = 1; tick();
    total_cnt++;
    if (digits0 !== 16'h9999 || wrap0 !== 1'b1) begin
      bad_cnt++; $display("FAIL underflow got=%h/%b want=9999/1", digits0, wrap0);
    end
    tick();
    total_cnt++;
    if (digits0 !== 16'h9998 || wrap0 !== 1'b0) begin
      bad_cnt++; $display("FAIL down_step got=%h/%b want=9998/0", digits0, wrap0);
    end
    total_cnt++;
    if (digits2 !== 16'h0000 || wrap2 !== 1'b0) begin
      bad_cnt++; $display("FAIL underflow_sat got=%h/%b want=0000/0", digits2, wrap2);
    end
    flag = 0;
  endtask

  task automatic test_saturate();
    idle(); load = 1; load_val = 16'h9999; tick();
    load = 0; dir = 1; flag = 1;
    for (int n = 0; n < 5; n++) begin
      tick();
      total_cnt++;
      if (digits2 !== 16'h9999 || wrap2 !== 1'b0 || at_limit2 !== 1'b1) begin
        bad_cnt++;
        $display("FAIL saturate cyc%0d got=%h/%b/%b want=9999/0/1", n, digits2, wrap2, at_limit2);
      end
    end
    flag = 0;
  endtask

  task automatic test_load_clamp();
    idle(); load = 1; load_val = 16'hA0F3; tick();
    total_cnt++;
    if (digits0 !== 16'h9093 || digits2 !== 16'h9093) begin
      bad_cnt++; $display("FAIL load_clamp got=%h,%h want=9093", digits0, digits2);
    end
    clear = 1; tick();
    total_cnt++;
    if (digits0 !== 16'h0000) begin
      bad_cnt++; $display("FAIL clear_over_load got=%h want=0000", digits0);
    end
    idle();
  endtask

  task automatic test_priority();
    idle(); load = 1; load_val = 16'h9999; tick();
    load = 0; rst = 1; flag = 1; dir = 1; tick();
    total_cnt++;
    if (digits0 !== 16'h0000 || wrap0 !== 1'b0) begin
      bad_cnt++; $display("FAIL rst_over_wrap got=%h/%b want=0000/0", digits0, wrap0);
    end
    idle(); load = 1; tick();
    load = 0; clear = 1; flag = 1; tick();
    total_cnt++;
    if (digits0 !== 16'h0000 || wrap0 !== 1'b0) begin
      bad_cnt++; $display("FAIL clear_over_wrap got=%h/%b want=0000/0", digits0, wrap0);
    end
    idle(); load = 1; load_val = 16'h9999; tick();
    load_val = 16'h1234; flag = 1; tick();
    total_cnt++;
    if (digits0 !== 16'h1234 || wrap0 !== 1'b0) begin
      bad_cnt++; $display("FAIL load_over_wrap got=%h/%b want=1234/0", digits0, wrap0);
    end
    idle(); tick();
    total_cnt++;
    if (digits0 !== 16'h1234 || wrap0 !== 1'b0) begin
      bad_cnt++; $display("FAIL idle_hold got=%h/%b want=1234/0", digits0, wrap0);
    end
  endtask

  task automatic test_random();
    logic exp_lim;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 149) == 0);
      clear = ($urandom_range(0, 79) == 0);
      load  = ($urandom_range(0, 24) == 0);
      flag  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      case ($urandom_range(0, 3))
        0:       begin load_val = 16'h9998; load_val2 = 8'h58; end
        1:       begin load_val = 16'h0001; load_val2 = 8'h01; end
        default: begin load_val = 16'($urandom); load_val2 = 8'($urandom); end
      endcase
      tick();
      for (int k = 0; k < 3; k++) begin
        exp_lim = dir ? (mval[k] == tot(k) - 1) : (mval[k] == 0);
        total_cnt++;
        if (dut_digits(k) !== int2vec(k, mval[k]) || dut_wrap(k) !== mwrap[k] ||
            dut_lim(k) !== exp_lim) begin
          bad_cnt++;
          $display("FAIL random dut%0d cyc%0d got=%h/%b/%b want=%h/%b/%b", k, n,
                   dut_digits(k), dut_wrap(k), dut_lim(k),
                   int2vec(k, mval[k]), mwrap[k], exp_lim);
        end
      end
    end
    idle();
  endtask

  initial begin
    rst = 0; flag = 0; dir = 1; clear = 0; load = 0;
    load_val = '0; load_val2 = '0;
    for (int k = 0; k < 3; k++) begin mval[k] = 0; mwrap[k] = 1'b0; end
    #2;
    test_reset();
    test_long_count();
    test_two_digit();
    test_down_wrap();
    test_saturate();
    test_load_clamp();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/multi_digit_counter.md
MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of cascaded digits, legal range 1..8.
REQ-002 Parameter DIGIT_W, default 4: bits per digit, legal range 2..8.
REQ-003 Parameter MAX_VALS, default all digits 9 (16'h9999 at defaults): packed NUM_DIGITS*DIGIT_W vector; digit i maximum in bits [i*DIGIT_W +: DIGIT_W], digit 0 least significant.
REQ-004 Parameter WRAP_EN, default 1: 1 means wrap on overflow/underflow; 0 means saturate.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 flag  input  1  count-enable qualifier, one step per clk edge sampled high.
REQ-008 dir  input  1  count direction: 1 up, 0 down.
REQ-009 clear  input  1  synchronous clear of all digits to 0.
REQ-010 load  input  1  synchronous parallel load strobe.
REQ-011 load_val  input  NUM_DIGITS*DIGIT_W  digit values for load, same packing as MAX_VALS.
REQ-012 digits  output  NUM_DIGITS*DIGIT_W  registered digit values.
REQ-013 wrap  output  1  registered one-cycle pulse on overflow or underflow of the whole chain.
REQ-014 at_limit  output  1  combinational: all digits at max when dir=1, or all digits 0 when dir=0.

Function
REQ-015 Priority per edge: rst > clear > load > flag; lower-priority inputs are ignored in that cycle.
REQ-016 The block SHALL leave digits unchanged and drive wrap low on any edge where rst, clear, load and flag are all low.
REQ-017 Up count: digit 0 SHALL step on flag; digit i>0 SHALL step when flag=1 and every lower digit equals its MAX; a digit at its MAX that steps SHALL go to 0, otherwise it SHALL go to value+1.
REQ-018 Down count: digit i SHALL step when flag=1 and every lower digit equals 0; a digit at 0 that steps SHALL go to its MAX, otherwise it SHALL go to value-1.
REQ-019 Latency: digits SHALL reflect a step on the same edge that samples flag=1; no pipeline delay.
REQ-020 Chain overflow (dir=1, flag=1, all digits at MAX): with WRAP_EN=1 all digits SHALL go to 0 and wrap SHALL be 1 for the following cycle only; with WRAP_EN=0 the digits SHALL hold and wrap SHALL stay 0.
REQ-021 Chain underflow (dir=0, flag=1, all digits 0): with WRAP_EN=1 all digits SHALL go to MAX_VALS and wrap SHALL pulse; with WRAP_EN=0 the digits SHALL hold.
REQ-022 Load: each digit SHALL take its load_val field; a field greater than that digit's MAX SHALL be clamped to MAX; wrap SHALL be 0.
REQ-023 Clear or load in the same cycle as an overflow condition SHALL suppress both the count and the wrap pulse.
REQ-024 dir may change on any cycle; the value sampled on the edge governs that step.
REQ-025 Digit values above MAX SHALL never be reachable after reset.

Reset
REQ-026 On rst=1 at a clk edge, all digits SHALL be set to 0 and wrap to 0; at_limit then follows dir.
REQ-027 Reset mid-count SHALL take effect on that edge regardless of flag, load or clear.

Structure
REQ-028 A shared package counter_pkg SHALL hold the default DIGIT_W, the default NUM_DIGITS and the direction encodings (DIR_UP=1, DIR_DOWN=0).
REQ-029 One sub-module digit_cell (one digit: value register, max, step-in, direction, clamped load, terminal-count out) SHALL be instantiated NUM_DIGITS times via generate, with terminal counts chained by an AND ripple.

Verification
REQ-030 Defaults, dir=1, flag high for 10000 cycles from reset -> digits 16'h9999 after 9999 edges, 16'h0000 and one wrap pulse after edge 10000.
REQ-031 NUM_DIGITS=2, MAX_VALS=8'h59, dir=1, from 8'h58 two flag edges -> 8'h59 then 8'h00, wrap pulses once.
REQ-032 Defaults, dir=0 from reset, one flag edge -> 16'h9999 with wrap pulse; next edge -> 16'h9998, wrap low.
REQ-033 WRAP_EN=0, load 16'h9999, dir=1, flag high 5 cycles -> digits hold 16'h9999, wrap never asserts, at_limit=1.
REQ-034 load_val 16'hA0F3 with default MAX -> digits 16'h9093; same cycle with clear=1 -> 16'h0000.
REQ-035 rst asserted on the edge where 16'h9999 would wrap with flag=1 -> digits 16'h0000, wrap stays 0.
